// File: rtl/register_file_scoreboard.sv
// Integer/float register files with a per-entry pending scoreboard; reads are 0-cycle with write forwarding, writes land 1 edge later, no backpressure.
// Define REGISTER_ZERO_HARDWIRED_EN to hardwire integer entry 0 to zero.
module register_file_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter int NUM_WRITE  = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
   input  logic [NUM_READ-1:0]              rd_float,
   output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
   output logic [NUM_READ-1:0]              rd_ready,
   input  logic [NUM_WRITE-1:0]             wr_enable,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  wr_addr,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wr_data,
   input  logic [NUM_WRITE-1:0]             wr_float,
   input  logic                             rsv_enable,
   input  logic [ADDR_WIDTH-1:0]            rsv_addr,
   input  logic                             rsv_float,
   output logic [ADDR_WIDTH+1:0]            pending_count
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int IW    = ADDR_WIDTH + 1;
   localparam int CW    = ADDR_WIDTH + 2;
`ifdef REGISTER_ZERO_HARDWIRED_EN
   localparam logic HW_ZERO = 1'b1;
`else
   localparam logic HW_ZERO = 1'b0;
`endif

   // Both files share one array indexed {float, addr}.
   logic [DATA_WIDTH-1:0] r_mem [2*DEPTH];
   logic [2*DEPTH-1:0]    r_pend;
   logic [CW-1:0]         r_count;

   logic [IW-1:0]         w_wr_idx [NUM_WRITE];
   logic [NUM_WRITE-1:0]  w_wr_vld;
   logic [IW-1:0]         w_rsv_idx;
   logic                  w_rsv_vld;

   for (genvar i = 0; i < NUM_WRITE; i++) begin : g_wr
      assign w_wr_idx[i] = {wr_float[i], wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]};
      // A hardwired zero entry neither stores nor forwards, so reads of it stay 0 and ready.
      assign w_wr_vld[i] = wr_enable[i] && !(HW_ZERO && (w_wr_idx[i] == '0));
   end

   assign w_rsv_idx = {rsv_float, rsv_addr};
   assign w_rsv_vld = rsv_enable && !(HW_ZERO && (w_rsv_idx == '0));

   function automatic logic [CW-1:0] popcount(input logic [2*DEPTH-1:0] v);
      logic [CW-1:0] s;
      s = '0;
      for (int k = 0; k < 2*DEPTH; k++) s = s + CW'(v[k]);
      return s;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2*DEPTH; k++) r_mem[k] <= '0;
         r_pend  <= '0;
         r_count <= '0;
      end else begin
         // Ascending port order: the last assignment, i.e. the highest port, wins.
         for (int i = 0; i < NUM_WRITE; i++) begin
            if (w_wr_vld[i]) begin
               r_mem[w_wr_idx[i]]  <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
               r_pend[w_wr_idx[i]] <= 1'b0;
            end
         end
         if (w_rsv_vld) r_pend[w_rsv_idx] <= 1'b1;
         r_count <= popcount(r_pend);
      end
   end

   assign pending_count = r_count;

   for (genvar j = 0; j < NUM_READ; j++) begin : g_rd
      logic [IW-1:0]         w_idx;
      logic [DATA_WIDTH-1:0] w_val;
      logic                  w_fwd;

      assign w_idx = {rd_float[j], rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH]};

      always_comb begin
         w_val = r_mem[w_idx];
         w_fwd = 1'b0;
         for (int i = 0; i < NUM_WRITE; i++) begin
            if (w_wr_vld[i] && (w_wr_idx[i] == w_idx)) begin
               w_val = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
               w_fwd = 1'b1;
            end
         end
      end

      // Stored state is already cleared during reset; only forwarding needs masking.
      assign rd_data[j*DATA_WIDTH +: DATA_WIDTH] = reset ? '0 : w_val;
      assign rd_ready[j] = !r_pend[w_idx] || (w_fwd && !reset);
   end
endmodule
